// File: rtl/dds_chirp_rx.sv
// DDS-side receiver for the four-phase REQ/ACK parameter transfer, plus the
// linear-FM chirp phase generator that runs from the captured parameters.
module dds_chirp_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PHASE_OUT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   REQ,
    input  logic [47:0]            DATA_FREQ,
    input  logic [47:0]            DATA_DELTA_FREQ,
    input  logic [31:0]            DATA_DELTA_RATE,
    output logic                   ACK,
    input  logic                   START,
    output logic                   NEW_DATA,
    output logic                   RUN,
    output logic [47:0]            FTW,
    output logic [PHASE_OUT_W-1:0] PHASE
);
    typedef enum logic {WAIT_REQ = 1'b0, HOLD = 1'b1} rx_state_t;
    typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_t;

    logic [SYNC_STAGES-1:0] req_sync_r;
    logic [SYNC_STAGES-1:0] start_sync_r;
    logic                   req_s;
    logic                   start_s;
    logic                   start_d_r;
    logic                   start_rise_s;

    rx_state_t   rx_state_r;
    rx_state_t   rx_next_s;
    logic        ack_r;
    logic        new_data_r;
    logic        ack_nxt_s;
    logic        load_sh_s;
    logic [47:0] sh_freq_r;
    logic [47:0] sh_dfreq_r;
    logic [31:0] sh_drate_r;

    ch_state_t   ch_state_r;
    ch_state_t   ch_next_s;
    logic        run_r;
    logic [47:0] ftw_r;
    logic [47:0] ftw_nxt_s;
    logic [47:0] phase_acc_r;
    logic [47:0] phase_acc_nxt_s;
    logic [47:0] w_dfreq_r;
    logic [47:0] w_dfreq_nxt_s;
    logic [31:0] w_drate_r;
    logic [31:0] w_drate_nxt_s;
    logic [31:0] rate_cnt_r;
    logic [31:0] rate_cnt_nxt_s;

    // Metastability chains for the two asynchronous control levels, plus the START edge delay.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_sync_r   <= '0;
            start_sync_r <= '0;
            start_d_r    <= 1'b0;
        end else begin
            req_sync_r   <= {req_sync_r[SYNC_STAGES-2:0], REQ};
            start_sync_r <= {start_sync_r[SYNC_STAGES-2:0], START};
            start_d_r    <= start_s;
        end
    end

    assign req_s        = req_sync_r[SYNC_STAGES-1];
    assign start_s      = start_sync_r[SYNC_STAGES-1];
    assign start_rise_s = start_s & ~start_d_r;

    // Receiver state, acknowledge and shadow registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_state_r <= WAIT_REQ;
            ack_r      <= 1'b0;
            new_data_r <= 1'b0;
            sh_freq_r  <= 48'd0;
            sh_dfreq_r <= 48'd0;
            sh_drate_r <= 32'd0;
        end else begin
            rx_state_r <= rx_next_s;
            ack_r      <= ack_nxt_s;
            new_data_r <= load_sh_s;
            if (load_sh_s) begin
                sh_freq_r  <= DATA_FREQ;
                sh_dfreq_r <= DATA_DELTA_FREQ;
                sh_drate_r <= DATA_DELTA_RATE;
            end
        end
    end

    // Receiver next-state: capture on synchronized REQ high, release on REQ low.
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            WAIT_REQ: if (req_s)  rx_next_s = HOLD;     else rx_next_s = WAIT_REQ;
            HOLD:     if (!req_s) rx_next_s = WAIT_REQ; else rx_next_s = HOLD;
            default:  rx_next_s = WAIT_REQ;
        endcase
    end

    // Receiver outputs: shadows load exactly once per transfer, on entry to HOLD.
    always_comb begin
        load_sh_s = (rx_state_r == WAIT_REQ) && req_s;
        ack_nxt_s = (rx_next_s == HOLD);
    end

    // Chirp state and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ch_state_r  <= CH_IDLE;
            run_r       <= 1'b0;
            ftw_r       <= 48'd0;
            phase_acc_r <= 48'd0;
            w_dfreq_r   <= 48'd0;
            w_drate_r   <= 32'd0;
            rate_cnt_r  <= 32'd0;
        end else begin
            ch_state_r  <= ch_next_s;
            run_r       <= (ch_next_s == CH_RUN);
            ftw_r       <= ftw_nxt_s;
            phase_acc_r <= phase_acc_nxt_s;
            w_dfreq_r   <= w_dfreq_nxt_s;
            w_drate_r   <= w_drate_nxt_s;
            rate_cnt_r  <= rate_cnt_nxt_s;
        end
    end

    // Chirp next-state: only a START rising edge arms, a low level stops.
    always_comb begin
        ch_next_s = ch_state_r;
        case (ch_state_r)
            CH_IDLE: if (start_rise_s) ch_next_s = CH_RUN;  else ch_next_s = CH_IDLE;
            CH_RUN:  if (!start_s)     ch_next_s = CH_IDLE; else ch_next_s = CH_RUN;
            default: ch_next_s = CH_IDLE;
        endcase
    end

    // Chirp datapath; working copies isolate a running burst from later captures.
    always_comb begin
        ftw_nxt_s       = ftw_r;
        phase_acc_nxt_s = phase_acc_r;
        w_dfreq_nxt_s   = w_dfreq_r;
        w_drate_nxt_s   = w_drate_r;
        rate_cnt_nxt_s  = rate_cnt_r;
        case (ch_state_r)
            CH_IDLE: begin
                if (start_rise_s) begin
                    ftw_nxt_s       = sh_freq_r;
                    w_dfreq_nxt_s   = sh_dfreq_r;
                    w_drate_nxt_s   = sh_drate_r;
                    phase_acc_nxt_s = 48'd0;
                    rate_cnt_nxt_s  = 32'd0;
                end else begin
                    ftw_nxt_s       = ftw_r;
                    phase_acc_nxt_s = phase_acc_r;
                end
            end
            CH_RUN: begin
                if (!start_s) begin
                    ftw_nxt_s       = 48'd0;
                    phase_acc_nxt_s = 48'd0;
                    rate_cnt_nxt_s  = 32'd0;
                end else begin
                    phase_acc_nxt_s = phase_acc_r + ftw_r;
                    if (rate_cnt_r == w_drate_r) begin
                        ftw_nxt_s      = ftw_r + w_dfreq_r;
                        rate_cnt_nxt_s = 32'd0;
                    end else begin
                        ftw_nxt_s      = ftw_r;
                        rate_cnt_nxt_s = rate_cnt_r + 32'd1;
                    end
                end
            end
            default: begin
                ftw_nxt_s       = 48'd0;
                phase_acc_nxt_s = 48'd0;
                rate_cnt_nxt_s  = 32'd0;
            end
        endcase
    end

    assign ACK      = ack_r;
    assign NEW_DATA = new_data_r;
    assign RUN      = run_r;
    assign FTW      = ftw_r;
    assign PHASE    = phase_acc_r[47 -: PHASE_OUT_W];

endmodule

// File: tb/tb_dds_chirp_rx.sv
// Directed self-checking bench for dds_chirp_rx: handshake timing, chirp
// trajectory, wrap, mid-run capture, capture/START collision and reset.
module tb_dds_chirp_rx;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ;
    logic        START;
    logic [47:0] DATA_FREQ;
    logic [47:0] DATA_DELTA_FREQ;
    logic [31:0] DATA_DELTA_RATE;
    logic        ACK;
    logic        NEW_DATA;
    logic        RUN;
    logic [47:0] FTW;
    logic [15:0] PHASE;

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] m_ftw, m_phase, m_dfreq;
    logic [31:0] m_cnt, m_drate;

    always #5 CLK = ~CLK;

    dds_chirp_rx #(.SYNC_STAGES(2), .PHASE_OUT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ),
        .DATA_FREQ(DATA_FREQ), .DATA_DELTA_FREQ(DATA_DELTA_FREQ), .DATA_DELTA_RATE(DATA_DELTA_RATE),
        .ACK(ACK), .START(START), .NEW_DATA(NEW_DATA), .RUN(RUN), .FTW(FTW), .PHASE(PHASE)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference chirp: phase accumulates the pre-edge tuning word, then the word steps.
    task automatic model_step();
        m_phase = m_phase + m_ftw;
        if (m_cnt == m_drate) begin
            m_ftw = m_ftw + m_dfreq;
            m_cnt = 32'd0;
        end else begin
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic do_transfer(input logic [47:0] f, input logic [47:0] d, input logic [31:0] r);
        DATA_FREQ = f; DATA_DELTA_FREQ = d; DATA_DELTA_RATE = r; REQ = 1'b1;
        for (int i = 0; i < 20 && ACK !== 1'b1; i++) step();
        n_tests++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL xfer_ack_rise: got %0b want 1", ACK); end
        REQ = 1'b0;
        for (int i = 0; i < 20 && ACK !== 1'b0; i++) step();
        n_tests++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL xfer_ack_fall: got %0b want 0", ACK); end
    endtask

    task automatic stop_chirp(input string tag);
        START = 1'b0;
        step(); step(); step();
        n_tests++; if (RUN !== 1'b0) begin n_fail++; $display("FAIL %s_stop_run: got %0b want 0", tag, RUN); end
        n_tests++; if (FTW !== 48'd0) begin n_fail++; $display("FAIL %s_stop_ftw: got %h want 0", tag, FTW); end
        n_tests++; if (PHASE !== 16'd0) begin n_fail++; $display("FAIL %s_stop_phase: got %h want 0", tag, PHASE); end
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ = 1'b0; START = 1'b0;
        DATA_FREQ = 48'd0; DATA_DELTA_FREQ = 48'd0; DATA_DELTA_RATE = 32'd0;
        step(); step(); step();
        n_tests++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %0b want 0", ACK); end
        n_tests++; if (NEW_DATA !== 1'b0) begin n_fail++; $display("FAIL rst_new_data: got %0b want 0", NEW_DATA); end
        n_tests++; if (RUN !== 1'b0) begin n_fail++; $display("FAIL rst_run: got %0b want 0", RUN); end
        n_tests++; if (FTW !== 48'd0) begin n_fail++; $display("FAIL rst_ftw: got %h want 0", FTW); end
        n_tests++; if (PHASE !== 16'd0) begin n_fail++; $display("FAIL rst_phase: got %h want 0", PHASE); end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_handshake();
        int pulses;
        DATA_FREQ = 48'h0000_1000_0000; DATA_DELTA_FREQ = 48'h10; DATA_DELTA_RATE = 32'd3;
        REQ = 1'b1;
        step(); step();
        n_tests++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL hs_ack_early: got %0b want 0", ACK); end
        n_tests++; if (NEW_DATA !== 1'b0) begin n_fail++; $display("FAIL hs_nd_early: got %0b want 0", NEW_DATA); end
        step();
        n_tests++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL hs_ack_rise: got %0b want 1", ACK); end
        n_tests++; if (NEW_DATA !== 1'b1) begin n_fail++; $display("FAIL hs_nd_pulse: got %0b want 1", NEW_DATA); end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (NEW_DATA === 1'b1) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL hs_extra_pulses: got %0d want 0", pulses); end
        n_tests++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL hs_ack_hold: got %0b want 1", ACK); end
        REQ = 1'b0;
        step(); step();
        n_tests++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL hs_ack_fall_early: got %0b want 1", ACK); end
        step();
        n_tests++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL hs_ack_fall: got %0b want 0", ACK); end
        step();
    endtask

    task automatic test_chirp_step();
        START = 1'b1;
        step(); step();
        n_tests++; if (RUN !== 1'b0) begin n_fail++; $display("FAIL cs_run_early: got %0b want 0", RUN); end
        step();
        n_tests++; if (RUN !== 1'b1) begin n_fail++; $display("FAIL cs_run: got %0b want 1", RUN); end
        n_tests++; if (FTW !== 48'h0000_1000_0000) begin n_fail++; $display("FAIL cs_ftw0: got %h want 000010000000", FTW); end
        m_ftw = 48'h0000_1000_0000; m_phase = 48'd0; m_dfreq = 48'h10; m_drate = 32'd3; m_cnt = 32'd0;
        for (int i = 0; i < 200; i++) begin
            step(); model_step();
            if (i == 3) begin
                n_tests++; if (FTW !== 48'h0000_1000_0010) begin n_fail++; $display("FAIL cs_first_step: got %h want 000010000010", FTW); end
            end
            n_tests++; if (FTW !== m_ftw) begin n_fail++; $display("FAIL cs_ftw[%0d]: got %h want %h", i, FTW, m_ftw); end
            n_tests++; if (PHASE !== m_phase[47:32]) begin n_fail++; $display("FAIL cs_phase[%0d]: got %h want %h", i, PHASE, m_phase[47:32]); end
        end
        stop_chirp("cs");
    endtask

    task automatic test_wrap();
        do_transfer(48'hFFFF_FFFF_FFF0, 48'h20, 32'd0);
        START = 1'b1;
        step(); step(); step();
        n_tests++; if (FTW !== 48'hFFFF_FFFF_FFF0) begin n_fail++; $display("FAIL wr_ftw0: got %h want fffffffffff0", FTW); end
        step();
        n_tests++; if (FTW !== 48'h0000_0000_0010) begin n_fail++; $display("FAIL wr_ftw1: got %h want 000000000010", FTW); end
        n_tests++; if (PHASE !== 16'hFFFF) begin n_fail++; $display("FAIL wr_phase1: got %h want ffff", PHASE); end
        step();
        n_tests++; if (FTW !== 48'h0000_0000_0030) begin n_fail++; $display("FAIL wr_ftw2: got %h want 000000000030", FTW); end
        n_tests++; if (PHASE !== 16'h0000) begin n_fail++; $display("FAIL wr_phase_wrap: got %h want 0000", PHASE); end
        stop_chirp("wr");
    endtask

    task automatic test_midrun_update();
        do_transfer(48'h0000_1000_0000, 48'h10, 32'd3);
        START = 1'b1;
        step(); step(); step();
        m_ftw = 48'h0000_1000_0000; m_phase = 48'd0; m_dfreq = 48'h10; m_drate = 32'd3; m_cnt = 32'd0;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) begin
                DATA_FREQ = 48'h5000; DATA_DELTA_FREQ = 48'h1; DATA_DELTA_RATE = 32'd0; REQ = 1'b1;
            end
            if (i == 15) REQ = 1'b0;
            step(); model_step();
            if (i == 4) begin
                n_tests++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL mu_ack: got %0b want 1", ACK); end
            end
            n_tests++; if (FTW !== m_ftw) begin n_fail++; $display("FAIL mu_ftw[%0d]: got %h want %h", i, FTW, m_ftw); end
        end
        stop_chirp("mu");
        START = 1'b1;
        step(); step(); step();
        n_tests++; if (RUN !== 1'b1) begin n_fail++; $display("FAIL mu_rerun: got %0b want 1", RUN); end
        n_tests++; if (FTW !== 48'h5000) begin n_fail++; $display("FAIL mu_new_ftw: got %h want 000000005000", FTW); end
        stop_chirp("mu2");
    endtask

    task automatic test_collision();
        DATA_FREQ = 48'h0000_7000_0000; DATA_DELTA_FREQ = 48'h2; DATA_DELTA_RATE = 32'd1;
        REQ = 1'b1; START = 1'b1;
        step(); step(); step();
        n_tests++; if (NEW_DATA !== 1'b1) begin n_fail++; $display("FAIL co_nd: got %0b want 1", NEW_DATA); end
        n_tests++; if (RUN !== 1'b1) begin n_fail++; $display("FAIL co_run: got %0b want 1", RUN); end
        n_tests++; if (FTW !== 48'h5000) begin n_fail++; $display("FAIL co_old_ftw: got %h want 000000005000", FTW); end
        step();
        n_tests++; if (FTW !== 48'h5001) begin n_fail++; $display("FAIL co_old_step: got %h want 000000005001", FTW); end
        REQ = 1'b0;
        stop_chirp("co");
        step();
        n_tests++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL co_ack_fall: got %0b want 0", ACK); end
        START = 1'b1;
        step(); step(); step();
        n_tests++; if (FTW !== 48'h0000_7000_0000) begin n_fail++; $display("FAIL co_new_ftw: got %h want 000070000000", FTW); end
        step(); step();
        n_tests++; if (FTW !== 48'h0000_7000_0002) begin n_fail++; $display("FAIL co_new_step: got %h want 000070000002", FTW); end
        stop_chirp("co2");
    endtask

    task automatic test_reset_midtransfer();
        DATA_FREQ = 48'h1234; DATA_DELTA_FREQ = 48'd0; DATA_DELTA_RATE = 32'd0;
        REQ = 1'b1; START = 1'b1;
        step(); step(); step(); step();
        n_tests++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL rm_pre_ack: got %0b want 1", ACK); end
        n_tests++; if (RUN !== 1'b1) begin n_fail++; $display("FAIL rm_pre_run: got %0b want 1", RUN); end
        RESET = 1'b1; START = 1'b0;
        step();
        n_tests++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL rm_ack: got %0b want 0", ACK); end
        n_tests++; if (RUN !== 1'b0) begin n_fail++; $display("FAIL rm_run: got %0b want 0", RUN); end
        n_tests++; if (FTW !== 48'd0) begin n_fail++; $display("FAIL rm_ftw: got %h want 0", FTW); end
        n_tests++; if (PHASE !== 16'd0) begin n_fail++; $display("FAIL rm_phase: got %h want 0", PHASE); end
        n_tests++; if (NEW_DATA !== 1'b0) begin n_fail++; $display("FAIL rm_nd: got %0b want 0", NEW_DATA); end
        step();
        RESET = 1'b0;
        step(); step();
        n_tests++; if (ACK !== 1'b0) begin n_fail++; $display("FAIL rm_ack_early: got %0b want 0", ACK); end
        step();
        n_tests++; if (ACK !== 1'b1) begin n_fail++; $display("FAIL rm_ack_again: got %0b want 1", ACK); end
        n_tests++; if (NEW_DATA !== 1'b1) begin n_fail++; $display("FAIL rm_nd_again: got %0b want 1", NEW_DATA); end
        step();
        n_tests++; if (NEW_DATA !== 1'b0) begin n_fail++; $display("FAIL rm_nd_single: got %0b want 0", NEW_DATA); end
        n_tests++; if (RUN !== 1'b0) begin n_fail++; $display("FAIL rm_run_idle: got %0b want 0", RUN); end
        REQ = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_chirp_step();
        test_wrap();
        test_midrun_update();
        test_collision();
        test_reset_midtransfer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
